// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and frame constants.
package uart_pkg;

   localparam int          DATA_BITS   = 8;
   localparam int unsigned DEFAULT_DIV = 234;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte handshake and line outputs of the UART transmitter.
interface uart_tx_if;
   logic [7:0] data;
   logic       req;
   logic       ready;
   logic       busy;
   logic       txd;

   modport master (output data, req, input ready, busy, txd);
   modport slave  (input data, req, output ready, busy, txd);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit timebase: tick pulses for one clock every div clocks; clear holds the count at zero.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned div = DEFAULT_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned       CNT_W = $clog2(div);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(div - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter (8 data bits, LSB first, 1 or 2 stop bits) with a one-entry holding register.
// Define UARTTX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned div       = DEFAULT_DIV,
   parameter int unsigned stop_bits = 1
) (
   input  logic     clk,
   input  logic     rst,
   uart_tx_if.slave bus
);

   state_t                 state_q, state_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   hold_q, hold_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   ready_q, ready_d;
   logic                   busy_q, busy_d;
   logic                   txd_q, txd_d;
`ifdef UARTTX_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   logic tick;
   logic accept;
   logic load;

   // Counter is held at zero while idle so every frame starts on a full bit period.
   uart_baud_gen #(.div(div)) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (state_q == ST_IDLE),
      .tick  (tick)
   );

   assign accept = bus.req && ready_q;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      hold_d    = hold_q;
      bit_cnt_d = bit_cnt_q;
      ready_d   = ready_q;
      load      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!ready_q) begin
               load    = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
`ifdef UARTTX_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = shift_q >> 1;
               end
            end
         end
`ifdef UARTTX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_d   = ST_STOP;
               bit_cnt_d = '0;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (bit_cnt_q == 3'(stop_bits - 1)) begin
                  bit_cnt_d = '0;
                  // A queued byte starts its start bit straight after the last stop clock.
                  if (!ready_q) begin
                     load    = 1'b1;
                     state_d = ST_START;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load) begin
         shift_d = hold_q;
         ready_d = 1'b1;
      end
      if (accept) begin
         hold_d  = bus.data;
         ready_d = 1'b0;
      end
   end

`ifdef UARTTX_PARITY_EN
   always_comb begin
      parity_d = parity_q;
      if (load) begin
         parity_d = ^hold_q;
      end
   end
`endif

   // Line level is derived from the next state so txd lands on the same edge as the state.
   always_comb begin
      busy_d = (state_d != ST_IDLE);
      txd_d  = 1'b1;
      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_d[0];
`ifdef UARTTX_PARITY_EN
         ST_PARITY: txd_d = parity_d;
`endif
         default:   txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         hold_q    <= '0;
         bit_cnt_q <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         txd_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         hold_q    <= hold_d;
         bit_cnt_q <= bit_cnt_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         txd_q     <= txd_d;
      end
   end

`ifdef UARTTX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.txd   = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, single frame, back-to-back, overrun, mid-frame reset, two stop bits.
module tb_uart_tx;

   localparam int DIV = 4;
`ifdef UARTTX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME1 = (1 + 8 + PAR + 1) * DIV;
   localparam int FRAME2 = (1 + 8 + PAR + 2) * DIV;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   uart_tx_if bus ();
   uart_tx_if bus2 ();

   uart_tx #(.div(DIV), .stop_bits(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   uart_tx #(.div(DIV), .stop_bits(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected line level k clocks after the start bit begins (stop bits are implied by frame length).
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      int idx;
      idx = k / DIV;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UARTTX_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic test_reset();
      logic [2:0] act;
      bus.req = 1'b0;  bus.data = 8'h00;
      bus2.req = 1'b0; bus2.data = 8'h00;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      act = {bus.txd, bus.ready, bus.busy};
      checks++;
      if (act !== 3'b110) begin
         failures++;
         $display("FAIL reset_async dut1 txd/ready/busy=%b required 110", act);
      end
      act = {bus2.txd, bus2.ready, bus2.busy};
      checks++;
      if (act !== 3'b110) begin
         failures++;
         $display("FAIL reset_async dut2 txd/ready/busy=%b required 110", act);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 2 * DIV; k++) begin
         @(negedge clk);
         act = {bus.txd, bus.ready, bus.busy};
         checks++;
         if (act !== 3'b110) begin
            failures++;
            $display("FAIL reset_release k=%0d txd/ready/busy=%b required 110", k, act);
         end
      end
      $display("reset: outputs idle during and after reset");
   endtask

   task automatic test_single(input logic [7:0] b);
      logic [2:0] act, exp;
      @(negedge clk);
      bus.data = b; bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0; bus.data = 8'h00;
      act = {bus.txd, bus.ready, bus.busy};
      checks++;
      if (act !== 3'b100) begin
         failures++;
         $display("FAIL single_accept byte=%02h txd/ready/busy=%b required 100", b, act);
      end
      for (int k = 0; k < FRAME1; k++) begin
         @(negedge clk);
         exp = {frame_bit(b, k), 2'b11};
         act = {bus.txd, bus.ready, bus.busy};
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL single_frame byte=%02h k=%0d txd/ready/busy=%b required %b", b, k, act, exp);
         end
      end
      @(negedge clk);
      act = {bus.txd, bus.ready, bus.busy};
      checks++;
      if (act !== 3'b110) begin
         failures++;
         $display("FAIL single_end byte=%02h txd/ready/busy=%b required 110", b, act);
      end
      $display("single: byte 0x%02h, %0d busy clks expected", b, FRAME1);
   endtask

   task automatic test_back_to_back();
      logic [7:0] b0, b1, fb, dec0, dec1;
      logic [2:0] act, exp;
      int off, idx;
      b0 = 8'hA5; b1 = 8'h3C; dec0 = 8'h00; dec1 = 8'h00;
      @(negedge clk);
      bus.data = b0; bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0; bus.data = 8'h00;
      for (int k = 0; k < 2 * FRAME1; k++) begin
         @(negedge clk);
         fb  = (k < FRAME1) ? b0 : b1;
         off = k % FRAME1;
         idx = off / DIV;
         exp = {frame_bit(fb, off), ((k >= 9) && (k < FRAME1)) ? 1'b0 : 1'b1, 1'b1};
         act = {bus.txd, bus.ready, bus.busy};
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL b2b_frame k=%0d txd/ready/busy=%b required %b", k, act, exp);
         end
         if ((off % DIV == DIV / 2) && (idx >= 1) && (idx <= 8)) begin
            if (k < FRAME1) dec0[idx-1] = bus.txd;
            else            dec1[idx-1] = bus.txd;
         end
         if (k == 8) begin
            bus.data = b1; bus.req = 1'b1;
         end else if (k == 9) begin
            bus.req = 1'b0; bus.data = 8'h00;
         end
      end
      @(negedge clk);
      act = {bus.txd, bus.ready, bus.busy};
      checks++;
      if (act !== 3'b110) begin
         failures++;
         $display("FAIL b2b_end txd/ready/busy=%b required 110", act);
      end
      checks++;
      if (dec0 !== b0) begin
         failures++;
         $display("FAIL b2b_decode0 got %02h required %02h", dec0, b0);
      end
      checks++;
      if (dec1 !== b1) begin
         failures++;
         $display("FAIL b2b_decode1 got %02h required %02h", dec1, b1);
      end
      $display("back_to_back: decoded 0x%02h then 0x%02h", dec0, dec1);
   endtask

   task automatic test_overrun();
      logic [7:0] b0, b1, fb;
      logic [2:0] act, exp;
      b0 = 8'h12; b1 = 8'h34;
      @(negedge clk);
      bus.data = b0; bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0; bus.data = 8'h00;
      for (int k = 0; k < 2 * FRAME1; k++) begin
         @(negedge clk);
         fb  = (k < FRAME1) ? b0 : b1;
         exp = {frame_bit(fb, k % FRAME1), ((k >= 3) && (k < FRAME1)) ? 1'b0 : 1'b1, 1'b1};
         act = {bus.txd, bus.ready, bus.busy};
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL overrun_frame k=%0d txd/ready/busy=%b required %b", k, act, exp);
         end
         if (k == 2) begin
            bus.data = b1; bus.req = 1'b1;
         end else if (k == 3) begin
            bus.req = 1'b0; bus.data = 8'h00;
         end else if (k == 5) begin
            bus.data = 8'hFF; bus.req = 1'b1;
         end else if (k == 6) begin
            bus.req = 1'b0; bus.data = 8'h00;
         end
      end
      for (int k = 0; k < 2 * DIV; k++) begin
         @(negedge clk);
         act = {bus.txd, bus.ready, bus.busy};
         checks++;
         if (act !== 3'b110) begin
            failures++;
            $display("FAIL overrun_idle k=%0d txd/ready/busy=%b required 110", k, act);
         end
      end
      $display("overrun: 0x%02h, 0x%02h sent, 0xff dropped", b0, b1);
   endtask

   task automatic test_mid_reset();
      logic [7:0] b;
      logic [2:0] act, exp;
      b = 8'h0F;
      @(negedge clk);
      bus.data = b; bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0; bus.data = 8'h00;
      // Stop inside data bit 3 (clocks 16..19 of the frame).
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         exp = {frame_bit(b, k), 2'b11};
         act = {bus.txd, bus.ready, bus.busy};
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL midreset_frame k=%0d txd/ready/busy=%b required %b", k, act, exp);
         end
      end
      rst = 1'b0;
      #1;
      act = {bus.txd, bus.ready, bus.busy};
      checks++;
      if (act !== 3'b110) begin
         failures++;
         $display("FAIL midreset_async txd/ready/busy=%b required 110", act);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 2 * DIV; k++) begin
         @(negedge clk);
         act = {bus.txd, bus.ready, bus.busy};
         checks++;
         if (act !== 3'b110) begin
            failures++;
            $display("FAIL midreset_idle k=%0d txd/ready/busy=%b required 110", k, act);
         end
      end
      $display("mid_reset: frame 0x%02h aborted", b);
      test_single(8'h01);
   endtask

   task automatic test_two_stop();
      logic [7:0] bytes [2];
      logic [7:0] b;
      logic [2:0] act, exp;
      bytes[0] = 8'h07;
      bytes[1] = 8'h03;
      for (int n = 0; n < 2; n++) begin
         b = bytes[n];
         @(negedge clk);
         bus2.data = b; bus2.req = 1'b1;
         @(negedge clk);
         bus2.req = 1'b0; bus2.data = 8'h00;
         for (int k = 0; k < FRAME2; k++) begin
            @(negedge clk);
            exp = {frame_bit(b, k), 2'b11};
            act = {bus2.txd, bus2.ready, bus2.busy};
            checks++;
            if (act !== exp) begin
               failures++;
               $display("FAIL two_stop_frame byte=%02h k=%0d txd/ready/busy=%b required %b", b, k, act, exp);
            end
         end
         @(negedge clk);
         act = {bus2.txd, bus2.ready, bus2.busy};
         checks++;
         if (act !== 3'b110) begin
            failures++;
            $display("FAIL two_stop_end byte=%02h txd/ready/busy=%b required 110", b, act);
         end
         $display("two_stop: byte 0x%02h, %0d busy clks expected", b, FRAME2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single(8'h55);
      test_back_to_back();
      test_overrun();
      test_mid_reset();
      test_two_stop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
